// File: rtl/imem_line_responder_pkg.sv
// Shared definitions for the instruction-memory line responder.
// Holds the FSM state encoding and the default "not ready" instruction.
package imem_line_responder_pkg;

  // Binary-encoded controller states. The unused code 2'b11 recovers to idle.
  typedef enum logic [1:0] {
    ILR_IDLE  = 2'b00,
    ILR_FILL  = 2'b01,
    ILR_DRAIN = 2'b10
  } ilr_state_e;

  // MIPS NOP: sll $0,$0,0.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/line_buf_ram.sv
// Line buffer storage: LINE_WORDS x 32-bit register array.
// Ports:
//   clk_i    clock
//   we_i     write enable, written on the rising edge
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  combinational read word index
//   rdata_o  combinational read data
module line_buf_ram #(
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned IdxW = $clog2(LINE_WORDS)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  logic [31:0]     wdata_i,
  input  logic [IdxW-1:0] raddr_i,
  output logic [31:0]     rdata_o
);

  // No reset: contents are only ever read under a valid line.
  logic [31:0] mem_q [LINE_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_line_responder.sv
// Instruction-fetch responder with a single line buffer.
// Hits are answered combinationally; a miss stalls the CPU (imem_ready=0)
// while the line is filled word by word from a req/ack backing memory.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   imem_addr/imem_read        CPU fetch address and request
//   imem_databus/imem_ready    instruction and valid/stall_n to the CPU
//   flush                      invalidate the line buffer
//   mem_req/mem_addr           backing-memory read request and word address
//   mem_ack/mem_rdata          backing-memory data valid and data
//   miss_cnt                   saturating count of line fills started
module imem_line_responder
  import imem_line_responder_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [31:0] MISS_INS   = MIPS_NOP,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      imem_addr,
  input  logic             imem_read,
  output logic [31:0]      imem_databus,
  output logic             imem_ready,
  input  logic             flush,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned IdxW = $clog2(LINE_WORDS);
  localparam int unsigned TagW = 30 - IdxW;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LINE_WORDS - 1);

  ilr_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [TagW-1:0]  tag_q, tag_d;
  // Only the tag part of the line base is stored; the low bits are always zero.
  logic [TagW-1:0]  base_q, base_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [TagW-1:0]  addr_tag;
  logic [IdxW-1:0]  addr_word;
  logic             hit;
  logic             ack;
  logic             ram_we;
  logic [31:0]      ram_rdata;
  logic             unused_addr_bits;

  assign addr_tag         = imem_addr[31:2+IdxW];
  assign addr_word        = imem_addr[1+IdxW:2];
  assign unused_addr_bits = ^imem_addr[1:0];

  line_buf_ram #(
    .LINE_WORDS(LINE_WORDS)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(idx_q),
    .wdata_i(mem_rdata),
    .raddr_i(addr_word),
    .rdata_o(ram_rdata)
  );

  // Outputs derived directly from state so reset drops mem_req on the next cycle.
  always_comb begin
    hit          = imem_read && valid_q && (addr_tag == tag_q) && (state_q == ILR_IDLE);
    mem_req      = (state_q == ILR_FILL) || (state_q == ILR_DRAIN);
    ack          = mem_req && mem_ack;
    imem_ready   = (state_q == ILR_IDLE) && (!imem_read || hit);
    imem_databus = hit ? ram_rdata : MISS_INS;
    mem_addr     = {base_q, idx_q, 2'b00};
    miss_cnt     = miss_cnt_q;
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    base_d     = base_q;
    miss_cnt_d = miss_cnt_q;
    ram_we     = 1'b0;
    case (state_q)
      ILR_IDLE: begin
        if (imem_read && !hit) begin
          base_d  = addr_tag;
          valid_d = 1'b0;
          idx_d   = '0;
          if (miss_cnt_q != {CNT_W{1'b1}}) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
          state_d = ILR_FILL;
        end else if (flush) begin
          valid_d = 1'b0;
        end
      end
      ILR_FILL: begin
        if (ack) begin
          ram_we = 1'b1;
          idx_d  = idx_q + IdxW'(1);
        end
        if (flush) begin
          // Abandon the line; wait out the outstanding request unless it just completed.
          valid_d = 1'b0;
          state_d = ack ? ILR_IDLE : ILR_DRAIN;
        end else if (ack && (idx_q == LastIdx)) begin
          valid_d = 1'b1;
          tag_d   = base_q;
          state_d = ILR_IDLE;
        end
      end
      ILR_DRAIN: begin
        if (ack) begin
          state_d = ILR_IDLE;
        end
      end
      default: begin
        state_d = ILR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ILR_IDLE;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      tag_q      <= '0;
      base_q     <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      base_q     <= base_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed self-checking bench for imem_line_responder.
// Main instance uses default parameters; a second small instance
// (LINE_WORDS=2, CNT_W=3, non-zero MISS_INS) exercises counter saturation.
module tb_imem_line_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr = '0;
  logic        imem_read = 1'b0;
  logic [31:0] imem_databus;
  logic        imem_ready;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] miss_cnt;

  logic [31:0] s_addr = '0;
  logic        s_read = 1'b0;
  logic [31:0] s_databus;
  logic        s_ready;
  logic        s_mem_req;
  logic [31:0] s_mem_addr;
  logic [2:0]  s_miss_cnt;

  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        man_ack = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] addr_log[$];

  always #5 clk = ~clk;

  // Backing memory returns data = address; ack after ack_delay waiting cycles.
  assign mem_ack   = man_ack || (mem_req && (wait_cnt >= ack_delay));
  assign mem_rdata = mem_addr;

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  imem_line_responder dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_read   (imem_read),
    .imem_databus(imem_databus),
    .imem_ready  (imem_ready),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .miss_cnt    (miss_cnt)
  );

  imem_line_responder #(
    .LINE_WORDS(2),
    .MISS_INS  (32'hDEAD_BEEF),
    .CNT_W     (3)
  ) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (s_addr),
    .imem_read   (s_read),
    .imem_databus(s_databus),
    .imem_ready  (s_ready),
    .flush       (1'b0),
    .mem_req     (s_mem_req),
    .mem_addr    (s_mem_addr),
    .mem_ack     (s_mem_req),
    .mem_rdata   (s_mem_addr),
    .miss_cnt    (s_miss_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts stall cycles until imem_ready rises, logging acked fill addresses.
  task automatic run_until_ready(output int low);
    low = 0;
    addr_log.delete();
    for (int c = 0; c < 200; c++) begin
      #1;
      if (imem_ready) return;
      low++;
      if (mem_req && mem_ack) addr_log.push_back(mem_addr);
      tick();
    end
    check_eq("ready_timeout", {31'd0, imem_ready}, 32'd1);
    low = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low;
    logic [31:0] exp_addr;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_ready", {31'd0, imem_ready}, 32'd1);
    check_eq("rst_data", imem_databus, 32'h0);
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);

    // 1: cold miss at 0x0, zero-wait memory
    ack_delay = 0;
    imem_read = 1'b1;
    imem_addr = 32'h0;
    run_until_ready(low);
    check_eq("t1_low_cycles", low, 32'd5);
    check_eq("t1_log_len", addr_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'(i * 4);
      check_eq("t1_fill_addr", (addr_log.size() > i) ? addr_log[i] : 32'hFFFF_FFFF, exp_addr);
    end
    check_eq("t1_data", imem_databus, 32'h0);
    check_eq("t1_ready", {31'd0, imem_ready}, 32'd1);
    check_eq("t1_miss_cnt", {16'd0, miss_cnt}, 32'd1);

    // 2: sweep the rest of the line, all hits
    for (int i = 1; i < 4; i++) begin
      tick();
      imem_addr = 32'(i * 4);
      #1;
      check_eq("t2_ready", {31'd0, imem_ready}, 32'd1);
      check_eq("t2_data", imem_databus, 32'(i * 4));
    end
    check_eq("t2_miss_cnt", {16'd0, miss_cnt}, 32'd1);

    // 3: miss at 0x10, 3 wait cycles per word
    tick();
    ack_delay = 3;
    imem_addr = 32'h10;
    run_until_ready(low);
    check_eq("t3_low_cycles", low, 32'd17);
    check_eq("t3_first_addr", (addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF, 32'h10);
    check_eq("t3_last_addr", (addr_log.size() > 3) ? addr_log[3] : 32'hFFFF_FFFF, 32'h1C);
    check_eq("t3_data", imem_databus, 32'h10);
    check_eq("t3_miss_cnt", {16'd0, miss_cnt}, 32'd2);

    // 4: flush on the 2nd fill cycle, ack delay 2 -> drain then idle with line invalid
    tick();
    ack_delay = 2;
    imem_addr = 32'h20;
    #1;
    check_eq("t4_miss_ready", {31'd0, imem_ready}, 32'd0);
    tick();
    #1;
    check_eq("t4_fill1_req", {31'd0, mem_req}, 32'd1);
    tick();
    flush = 1'b1;
    #1;
    check_eq("t4_fill2_req", {31'd0, mem_req}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    check_eq("t4_drain_req", {31'd0, mem_req}, 32'd1);
    check_eq("t4_drain_addr", mem_addr, 32'h20);
    check_eq("t4_drain_ready", {31'd0, imem_ready}, 32'd0);
    tick();
    imem_addr = 32'h10;
    #1;
    check_eq("t4_idle_req", {31'd0, mem_req}, 32'd0);
    check_eq("t4_cnt_before", {16'd0, miss_cnt}, 32'd3);
    run_until_ready(low);
    check_eq("t4_refetch_low", low, 32'd13);
    check_eq("t4_data", imem_databus, 32'h10);
    check_eq("t4_miss_cnt", {16'd0, miss_cnt}, 32'd4);

    // 5: reset mid-fill, late ack afterwards is ignored
    tick();
    ack_delay = 100;
    imem_addr = 32'h40;
    #1;
    check_eq("t5_miss_ready", {31'd0, imem_ready}, 32'd0);
    tick();
    tick();
    #1;
    check_eq("t5_fill_req", {31'd0, mem_req}, 32'd1);
    check_eq("t5_fill_addr", mem_addr, 32'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    man_ack = 1'b1;
    imem_read = 1'b0;
    #1;
    check_eq("t5_req_after_rst", {31'd0, mem_req}, 32'd0);
    check_eq("t5_cnt_after_rst", {16'd0, miss_cnt}, 32'd0);
    check_eq("t5_ready_after_rst", {31'd0, imem_ready}, 32'd1);
    tick();
    man_ack = 1'b0;
    ack_delay = 0;
    imem_read = 1'b1;
    run_until_ready(low);
    check_eq("t5_refill_low", low, 32'd5);
    check_eq("t5_data", imem_databus, 32'h40);
    check_eq("t5_miss_cnt", {16'd0, miss_cnt}, 32'd1);

    // 6: no read request -> always ready, MISS_INS, no memory traffic
    tick();
    imem_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      imem_addr = $urandom;
      #1;
      check_eq("t6_ready", {31'd0, imem_ready}, 32'd1);
      check_eq("t6_data", imem_databus, 32'h0);
      check_eq("t6_no_req", {31'd0, mem_req}, 32'd0);
      tick();
    end
    check_eq("t6_miss_cnt", {16'd0, miss_cnt}, 32'd1);

    // Saturation on the narrow-counter instance: 10 misses into a 3-bit counter
    s_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_addr = 32'(i * 8 + 4);
      tick();
      tick();
      tick();
      #1;
      check_eq("sat_hit_ready", {31'd0, s_ready}, 32'd1);
      check_eq("sat_hit_data", s_databus, 32'(i * 8 + 4));
      if (i == 5) check_eq("sat_cnt_6", {29'd0, s_miss_cnt}, 32'd6);
      tick();
    end
    check_eq("sat_cnt_max", {29'd0, s_miss_cnt}, 32'd7);
    s_read = 1'b0;
    #1;
    check_eq("sat_miss_ins", s_databus, 32'hDEAD_BEEF);
    check_eq("sat_idle_ready", {31'd0, s_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_line_responder.md
Name: imem_line_responder

Overview:
- Responder at the far end of the CPU instruction-fetch bus. The IF stage drives address/read and expects the instruction on the same cycle.
- Holds one 4-word line buffer and answers hits combinationally.
- On a miss, drops imem_ready (wired to the pipeline stall_n) and fills the line from a slower req/ack backing memory.
- Sits between the CPU top-level fetch port and the boot ROM/SRAM controller.

Parameters:
- LINE_WORDS, 4, words per line buffer; power of two, minimum 2.
- MISS_INS, 32'h00000000, instruction returned while not ready; the default is a MIPS NOP (sll $0,$0,0).
- CNT_W, 16, width of the saturating miss counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  in  32  fetch byte address from the CPU; bits [1:0] are ignored.
- imem_read  in  1  fetch request, level-sensitive.
- imem_databus  out  32  instruction to the CPU.
- imem_ready  out  1  1 = imem_databus is valid this cycle; 0 = the CPU must stall.
- flush  in  1  invalidate the line buffer (self-modifying code or boot handoff).
- mem_req  out  1  backing-memory read request.
- mem_addr  out  32  backing-memory word address, byte-addressed and word-aligned.
- mem_ack  in  1  backing-memory data valid; may be asserted in the same cycle as mem_req.
- mem_rdata  in  32  backing-memory read data, sampled when mem_req && mem_ack.
- miss_cnt  out  CNT_W  number of line fills started, saturating.

Behaviour:
- Reset: state IDLE, valid=0, word index=0, mem_req=0, mem_addr=0, miss_cnt=0. With imem_read=0, imem_ready=1 and imem_databus=MISS_INS.
- Tag is imem_addr[31:2+log2(LINE_WORDS)]; word select is imem_addr[1+log2(LINE_WORDS):2].
- Hit is imem_read && valid && tag==stored_tag && state==IDLE. On a hit: imem_ready=1 and imem_databus=line[word]. Both are combinational with zero latency.
- imem_read=0: imem_ready=1, imem_databus=MISS_INS, no fill starts.
- Miss in IDLE (imem_read && !hit):
  - imem_ready=0 and imem_databus=MISS_INS in the same cycle.
  - Next edge: latch base = imem_addr with low bits cleared, valid<=0, index<=0, miss_cnt+=1 (saturates at all-ones), go to FILL.
- FILL:
  - mem_req=1 and mem_addr = base + 4*index.
  - Each mem_req&&mem_ack writes line[index]<=mem_rdata and index+=1. Only one request is outstanding.
  - On the ack for the last word: valid<=1, stored_tag<=base tag, go to IDLE.
  - imem_ready stays 0 for the whole of FILL.
- Miss penalty with zero-wait memory (ack in the same cycle as req): miss cycle, then LINE_WORDS FILL cycles, then the hit cycle. For LINE_WORDS=4, imem_ready is low for 5 cycles.
- Address changes during FILL are ignored. The fill completes for the latched base, then the address is re-evaluated in IDLE, which may produce a second miss.
- flush in IDLE: valid<=0 at the next edge. A hit in the flush cycle is still served.
- flush in FILL: the current word completes; the FSM goes to DRAIN.
  - DRAIN holds mem_req=1 until the outstanding ack arrives, then goes to IDLE with valid=0.
  - If the ack arrives in the flush cycle itself, go directly to IDLE with valid=0.
- rst during FILL/DRAIN: mem_req=0 from the next cycle. A late mem_ack with mem_req=0 is ignored.
- mem_ack with mem_req=0 is ignored in every state.
- States are IDLE, FILL, DRAIN, binary-encoded 2 bits; the code 2'b11 is illegal and recovers to IDLE.

Decomposition:
- Shared package holds: state encodings (ILR_IDLE=2'b00, ILR_FILL=2'b01, ILR_DRAIN=2'b10) and the MIPS NOP constant 32'h00000000.
- Sub-module line_buf_ram: LINE_WORDS x 32 register array, one write port, one combinational read port.
- FSM, tag compare and counter stay in the top module.

Test Plan:
1. Reset, imem_read=1, addr=0x00000000, zero-wait memory returning data=addr -> imem_ready low 5 cycles; mem_addr sequence 0x0,0x4,0x8,0xC; then imem_databus=0x00000000, ready=1, miss_cnt=1.
2. After test 1, addr sweeps 0x4, 0x8, 0xC -> ready=1 every cycle; data 0x4,0x8,0xC; miss_cnt stays 1.
3. addr=0x00000010 with mem_ack delayed 3 cycles per word -> ready low 17 cycles; then data=0x10; miss_cnt=2.
4. flush asserted on the 2nd FILL cycle with ack delayed 2 cycles -> mem_req stays high until that ack; FSM goes to IDLE with valid=0; the next fetch of 0x10 misses again; miss_cnt increments.
5. rst pulsed mid-FILL with mem_ack arriving 1 cycle later -> mem_req=0 next cycle; valid=0; the late ack does not write the line; miss_cnt=0.
6. imem_read=0 for 10 cycles with random addr -> ready=1, data=MISS_INS, mem_req never asserted. Force the miss count past 0xFFFF -> miss_cnt saturates at 0xFFFF.
